// File: rtl/prime_seq_checker.sv
// rtl/prime_seq_checker.sv - checks a 2->3->5->7 prime counter stream; lock, error and lap status (optional SEG7_DISP_EN display)
module prime_seq_checker #(
    parameter int LOCK_LEN   = 4,
    parameter int ERR_W      = 8,
    parameter int LAP_W      = 8,
    parameter int ALLOW_HOLD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       count_in,
    output logic             locked,
    output logic             seq_error,
    output logic [ERR_W-1:0] err_count,
    output logic [LAP_W-1:0] lap_count,
    output logic [2:0]       last_good,
    output logic [6:0]       seg_n
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);
    localparam logic [RUN_W-1:0] LOCK_LEN_V = RUN_W'(LOCK_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       prev;
    logic [RUN_W-1:0] run, run_nxt, run_inc;
    logic [2:0]       last_good_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [LAP_W-1:0] lap_nxt;
    logic             seq_error_nxt;
    logic             val_ok;
    logic             step_ok;

    function automatic logic is_legal(input logic [2:0] v);
        return (v == 3'd2) || (v == 3'd3) || (v == 3'd5) || (v == 3'd7);
    endfunction

    // Successor in the prime sequence; 0 for values outside it, which never matches a legal sample.
    function automatic logic [2:0] next_of(input logic [2:0] v);
        case (v)
            3'd2:    return 3'd3;
            3'd3:    return 3'd5;
            3'd5:    return 3'd7;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    assign val_ok  = is_legal(count_in);
    assign step_ok = val_ok && ((next_of(prev) == count_in) ||
                                ((ALLOW_HOLD != 0) && (prev == count_in)));
    assign run_inc = run + RUN_W'(1);
    assign locked  = (state == LOCKED);

    // Registers all checker state; prev tracks count_in unconditionally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= 3'd0;
            run       <= '0;
            last_good <= 3'd0;
            err_count <= '0;
            lap_count <= '0;
            seq_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= count_in;
            run       <= run_nxt;
            last_good <= last_good_nxt;
            err_count <= err_nxt;
            lap_count <= lap_nxt;
            seq_error <= seq_error_nxt;
        end
    end

    // Next-state and next-output decode for the IDLE/SEARCH/LOCKED tracker.
    always_comb begin
        state_nxt     = state;
        run_nxt       = run;
        last_good_nxt = last_good;
        err_nxt       = err_count;
        lap_nxt       = lap_count;
        seq_error_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (val_ok) begin
                    state_nxt     = SEARCH;
                    run_nxt       = '0;
                    last_good_nxt = count_in;
                end
            end
            SEARCH: begin
                if (step_ok) begin
                    last_good_nxt = count_in;
                    if (run_inc == LOCK_LEN_V) begin
                        state_nxt = LOCKED;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_inc;
                    end
                end else begin
                    run_nxt = '0;
                    if (!val_ok) begin
                        state_nxt = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (step_ok) begin
                    last_good_nxt = count_in;
                    if ((prev == 3'd7) && (count_in == 3'd2)) begin
                        lap_nxt = lap_count + LAP_W'(1);
                    end
                end else begin
                    seq_error_nxt = 1'b1;
                    if (err_count != {ERR_W{1'b1}}) begin
                        err_nxt = err_count + ERR_W'(1);
                    end
                    run_nxt   = '0;
                    state_nxt = val_ok ? SEARCH : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                run_nxt   = '0;
            end
        endcase
    end

`ifdef SEG7_DISP_EN
    // Registered active-low 7-segment code of the current sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n <= 7'h7F;
        end else begin
            case (count_in)
                3'd2:    seg_n <= 7'b0100100;
                3'd3:    seg_n <= 7'b0110000;
                3'd5:    seg_n <= 7'b0010010;
                3'd7:    seg_n <= 7'b1111000;
                default: seg_n <= 7'b0111111;
            endcase
        end
    end
`else
    assign seg_n = 7'h7F;
`endif

endmodule
